// File: rtl/capture_compare.sv
// Per-pin capture/expect comparator with masked compare, sticky fail flags,
// saturating fail counters and first-failure index tracking.
module capture_compare #(
    parameter int PINS  = 16,
    parameter int CNT_W = 16
) (
    input  logic             s_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cap_valid,
    input  logic [PINS-1:0]  cap_data,
    input  logic [PINS-1:0]  exp_data,
    input  logic [PINS-1:0]  exp_mask,
    input  logic             exp_empty,
    output logic             exp_rdreq,
    input  logic [3:0]       addr,
    output logic [CNT_W-1:0] fail_count,
    output logic [PINS-1:0]  fail_pins,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             underrun,
    output logic [1:0]       state_indication
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e            state_q;
    logic              clear;
    logic              accept;

    logic              mm_vld_q,   mm_vld_d;
    logic [PINS-1:0]   mm_vec_q,   mm_vec_d;
    logic [CNT_W-1:0]  mm_idx_q,   mm_idx_d;
    logic [CNT_W-1:0]  idx_q,      idx_d;
    logic              underrun_q, underrun_d;
    logic [PINS-1:0]   pins_q,     pins_d;
    logic [CNT_W-1:0]  first_q,    first_d;
    logic [CNT_W-1:0]  cnt_q [PINS];
    logic [CNT_W-1:0]  cnt_d [PINS];

    assign clear     = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign accept    = (state_q == ST_RUN) & cap_valid & ~exp_empty;
    assign exp_rdreq = accept;

    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_q <= ST_RUN;
                ST_RUN:   if (stop)  state_q <= ST_DRAIN;
                ST_DRAIN: state_q <= ST_DONE;
                ST_DONE:  if (start) state_q <= ST_RUN;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mm_vld_d   = accept;
        mm_vec_d   = accept ? ((cap_data ^ exp_data) & exp_mask) : '0;
        mm_idx_d   = idx_q;
        idx_d      = idx_q;
        underrun_d = underrun_q;
        pins_d     = pins_q;
        first_d    = first_q;
        cnt_d      = cnt_q;

        if (accept && (idx_q != '1)) idx_d = idx_q + CNT_W'(1);
        if ((state_q == ST_RUN) && cap_valid && exp_empty) underrun_d = 1'b1;

        // Commit stage runs in any state so a sample taken on the stop edge lands in DRAIN.
        if (mm_vld_q) begin
            for (int unsigned i = 0; i < PINS; i++) begin
                if (mm_vec_q[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            pins_d = pins_q | mm_vec_q;
            if ((pins_q == '0) && (mm_vec_q != '0)) first_d = mm_idx_q;
        end

        if (clear) begin
            mm_vld_d   = 1'b0;
            mm_vec_d   = '0;
            idx_d      = '0;
            underrun_d = 1'b0;
            pins_d     = '0;
            first_d    = '1;
            for (int unsigned i = 0; i < PINS; i++) cnt_d[i] = '0;
        end
    end

    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            mm_vld_q   <= 1'b0;
            mm_vec_q   <= '0;
            mm_idx_q   <= '0;
            idx_q      <= '0;
            underrun_q <= 1'b0;
            pins_q     <= '0;
            first_q    <= '1;
            for (int unsigned i = 0; i < PINS; i++) cnt_q[i] <= '0;
        end else begin
            mm_vld_q   <= mm_vld_d;
            mm_vec_q   <= mm_vec_d;
            mm_idx_q   <= mm_idx_d;
            idx_q      <= idx_d;
            underrun_q <= underrun_d;
            pins_q     <= pins_d;
            first_q    <= first_d;
            for (int unsigned i = 0; i < PINS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        fail_count = '0;
        for (int unsigned i = 0; i < PINS; i++) begin
            if ((i < 16) && (4'(i) == addr)) fail_count = cnt_q[i];
        end
    end

    assign fail_pins        = pins_q;
    assign first_fail_idx   = first_q;
    assign underrun         = underrun_q;
    assign busy             = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);
    assign pass             = done & (pins_q == '0) & ~underrun_q;
    assign state_indication = state_q;

endmodule

// File: tb/tb_capture_compare.sv
// Randomised and directed checks of capture_compare against a sample-list model.
module tb_capture_compare;

    logic        s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    logic        reset, start, stop, cap_valid, exp_empty;
    logic [15:0] cap_data, exp_data, exp_mask;
    logic [3:0]  addr;
    logic        exp_rdreq, busy, done, pass, underrun;
    logic [15:0] fail_count, fail_pins, first_fail_idx;
    logic [1:0]  state_indication;

    logic        s_start, s_stop, s_valid, s_empty;
    logic [15:0] s_cap, s_exp, s_mask;
    logic [3:0]  s_addr;
    logic        s_rdreq, s_busy, s_done, s_pass, s_under;
    logic [3:0]  s_count, s_first;
    logic [15:0] s_pins;
    logic [1:0]  s_state;

    capture_compare #(.PINS(16), .CNT_W(16)) dut (
        .s_clk(s_clk), .reset(reset), .start(start), .stop(stop),
        .cap_valid(cap_valid), .cap_data(cap_data), .exp_data(exp_data),
        .exp_mask(exp_mask), .exp_empty(exp_empty), .exp_rdreq(exp_rdreq),
        .addr(addr), .fail_count(fail_count), .fail_pins(fail_pins),
        .first_fail_idx(first_fail_idx), .busy(busy), .done(done), .pass(pass),
        .underrun(underrun), .state_indication(state_indication)
    );

    capture_compare #(.PINS(16), .CNT_W(4)) dut_sat (
        .s_clk(s_clk), .reset(reset), .start(s_start), .stop(s_stop),
        .cap_valid(s_valid), .cap_data(s_cap), .exp_data(s_exp),
        .exp_mask(s_mask), .exp_empty(s_empty), .exp_rdreq(s_rdreq),
        .addr(s_addr), .fail_count(s_count), .fail_pins(s_pins),
        .first_fail_idx(s_first), .busy(s_busy), .done(s_done), .pass(s_pass),
        .underrun(s_under), .state_indication(s_state)
    );

    int total = 0;
    int bad   = 0;
    int rdp   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: every accepted sample becomes visible in the results one edge after the edge that took it.
    typedef struct { logic [15:0] vec; logic [15:0] idx; } samp_t;
    samp_t       pend[$];
    samp_t       due[$];
    int          mstate;
    int          mcnt[16];
    logic [15:0] mpins, mfirst;
    bit          mund;
    int          midx;

    task automatic mclear();
        foreach (mcnt[i]) mcnt[i] = 0;
        mpins = '0; mfirst = 16'hFFFF; mund = 0; midx = 0; pend = {};
    endtask

    task automatic mcommit(input samp_t s);
        for (int p = 0; p < 16; p++) if (s.vec[p] && mcnt[p] < 65535) mcnt[p]++;
        if (mpins == 0 && s.vec != 0) mfirst = s.idx;
        mpins |= s.vec;
    endtask

    task automatic mstep();
        due = pend;
        pend = {};
        foreach (due[i]) mcommit(due[i]);
        if (mstate == 0 || mstate == 3) begin
            if (start) begin mclear(); mstate = 1; end
        end else if (mstate == 1) begin
            if (cap_valid && !exp_empty) begin
                pend.push_back('{(cap_data ^ exp_data) & exp_mask, midx[15:0]});
                if (midx < 65535) midx++;
            end else if (cap_valid) begin
                mund = 1;
            end
            if (stop) mstate = 2;
        end else begin
            mstate = 3;
        end
    endtask

    initial begin
        mstate = 0; mclear();
        forever begin
            @(posedge s_clk or negedge reset);
            if (!reset) begin mstate = 0; mclear(); end
            else mstep();
        end
    end

    initial begin
        forever begin
            @(negedge s_clk);
            if (exp_rdreq) rdp++;
            if (chk_en) begin
                chk("state",  32'(state_indication), 32'(mstate));
                chk("busy",   32'(busy),     32'(mstate == 1 || mstate == 2));
                chk("done",   32'(done),     32'(mstate == 3));
                chk("pass",   32'(pass),     32'(mstate == 3 && mpins == 0 && !mund));
                chk("underrun", 32'(underrun), 32'(mund));
                chk("rdreq",  32'(exp_rdreq), 32'(mstate == 1 && cap_valid && !exp_empty));
                chk("pins",   32'(fail_pins), 32'(mpins));
                chk("first",  32'(first_fail_idx), 32'(mfirst));
                chk("count",  32'(fail_count), 32'(mcnt[addr]));
            end
        end
    end

    task automatic tick();
        @(posedge s_clk);
        #2;
    endtask

    task automatic idle_in();
        start = 0; stop = 0; cap_valid = 0; exp_empty = 0;
        cap_data = '0; exp_data = '0; exp_mask = '0;
    endtask

    task automatic sample(input logic [15:0] c, input logic [15:0] e, input logic [15:0] m);
        cap_valid = 1; cap_data = c; exp_data = e; exp_mask = m;
        tick();
        cap_valid = 0;
    endtask

    task automatic finish_run();
        stop = 1; tick(); stop = 0;
        tick(); tick();
    endtask

    task automatic s_sample(input logic [15:0] c, input logic [15:0] e);
        s_valid = 1; s_cap = c; s_exp = e; s_mask = 16'h0001;
        tick();
        s_valid = 0;
    endtask

    initial begin
        reset = 0; idle_in(); addr = 0;
        s_start = 0; s_stop = 0; s_valid = 0; s_empty = 0;
        s_cap = '0; s_exp = '0; s_mask = '0; s_addr = 0;
        tick(); tick();
        reset = 1; chk_en = 1;
        tick();
        chk("rst_state", 32'(state_indication), 32'd0);
        chk("rst_first", 32'(first_fail_idx), 32'hFFFF);
        chk("rst_busy",  32'(busy), 32'd0);

        // all-match run
        rdp = 0;
        start = 1; tick(); start = 0;
        repeat (4) sample(16'hA5A5, 16'hA5A5, 16'hFFFF);
        finish_run();
        chk("m_done",  32'(done), 32'd1);
        chk("m_pass",  32'(pass), 32'd1);
        chk("m_pins",  32'(fail_pins), 32'd0);
        chk("m_first", 32'(first_fail_idx), 32'hFFFF);
        chk("m_pops",  32'(rdp), 32'd4);

        // masked mismatch on sample 2
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) sample(16'h0001, 16'h0003, 16'h0002);
            else        sample(16'h0000, 16'h0000, 16'hFFFF);
        end
        finish_run();
        addr = 1; #1;
        chk("mm_cnt1",  32'(fail_count), 32'd1);
        addr = 0; #1;
        chk("mm_cnt0",  32'(fail_count), 32'd0);
        chk("mm_pins",  32'(fail_pins), 32'h0002);
        chk("mm_first", 32'(first_fail_idx), 32'd2);
        chk("mm_pass",  32'(pass), 32'd0);

        // start wins over stop; sample on the stop edge is counted
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        chk("pri_state", 32'(state_indication), 32'd1);
        cap_valid = 1; cap_data = 16'h0000; exp_data = 16'hFFFF; exp_mask = 16'h0010; stop = 1;
        tick(); cap_valid = 0; stop = 0;
        chk("lat_drain", 32'(state_indication), 32'd2);
        chk("lat_nodone", 32'(done), 32'd0);
        tick();
        chk("lat_done",  32'(done), 32'd1);
        chk("lat_pins",  32'(fail_pins), 32'h0010);
        chk("lat_first", 32'(first_fail_idx), 32'd0);

        // underrun: starved sample not indexed
        start = 1; tick(); start = 0;
        cap_valid = 1; exp_empty = 1; #1;
        chk("ur_rdreq", 32'(exp_rdreq), 32'd0);
        tick(); cap_valid = 0; exp_empty = 0;
        chk("ur_flag", 32'(underrun), 32'd1);
        sample(16'h0004, 16'h0000, 16'hFFFF);
        finish_run();
        chk("ur_first", 32'(first_fail_idx), 32'd0);
        chk("ur_pass",  32'(pass), 32'd0);

        // reset mid-run, then clean run
        start = 1; tick(); start = 0;
        repeat (3) sample(16'h00FF, 16'h0000, 16'hFFFF);
        tick(); tick();
        reset = 0; #1;
        chk("rr_state", 32'(state_indication), 32'd0);
        chk("rr_pins",  32'(fail_pins), 32'd0);
        chk("rr_first", 32'(first_fail_idx), 32'hFFFF);
        chk("rr_busy",  32'(busy), 32'd0);
        tick(); reset = 1; tick();
        start = 1; tick(); start = 0;
        repeat (2) sample(16'h1234, 16'h1234, 16'hFFFF);
        finish_run();
        chk("rr_pass", 32'(pass), 32'd1);

        // saturation with 4-bit counters
        s_start = 1; tick(); s_start = 0;
        repeat (20) s_sample(16'h0001, 16'h0000);
        s_stop = 1; tick(); s_stop = 0; tick(); tick();
        chk("sat_cnt",   32'(s_count), 32'd15);
        chk("sat_first", 32'(s_first), 32'd0);
        chk("sat_done",  32'(s_done), 32'd1);
        s_start = 1; tick(); s_start = 0;
        repeat (18) s_sample(16'h0000, 16'h0000);
        s_sample(16'h0001, 16'h0000);
        s_stop = 1; tick(); s_stop = 0; tick(); tick();
        chk("sat_idx",   32'(s_first), 32'd15);
        chk("sat_cnt1",  32'(s_count), 32'd1);
        chk("sat_pins",  32'(s_pins), 32'h0001);

        // randomised runs
        for (int r = 0; r < 40; r++) begin
            start = 1; stop = ($urandom_range(0, 3) == 0); tick(); start = 0; stop = 0;
            begin
                int len;
                len = $urandom_range(4, 40);
                for (int k = 0; k < len; k++) begin
                    cap_valid = ($urandom_range(0, 9) < 7);
                    exp_empty = ($urandom_range(0, 9) == 0);
                    cap_data  = 16'($urandom);
                    exp_data  = cap_data ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
                    exp_mask  = 16'($urandom) | 16'($urandom);
                    addr      = 4'($urandom_range(0, 15));
                    start     = ($urandom_range(0, 29) == 0);
                    reset     = !((r % 7 == 3) && (k == len / 2));
                    tick();
                end
            end
            reset = 1; start = 0;
            stop = 1; cap_valid = ($urandom_range(0, 1) == 1); tick(); stop = 0;
            repeat (3) begin
                cap_valid = ($urandom_range(0, 1) == 1);
                cap_data  = 16'($urandom);
                addr      = 4'($urandom_range(0, 15));
                tick();
            end
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
